divu_seq: RTL and testbench
===========================

Name: divu_seq

Overview:
- Iterative unsigned integer divider; computes quotient and remainder of a_bi / b_bi, one restoring shift-subtract step per clock.
- Responder side of the start/busy compute-unit protocol used by the accelerator datapath. It sits beside mult and cbrt as a multi-cycle arithmetic unit that a controller starts and then polls via busy_o.
- Operands are captured on start. Results are held stable from the falling edge of busy_o until the next start.

Parameters:
- WIDTH, 8, operand/result bit width (minimum 2).

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low (0 = reset).
- start_i  input  1  request; level-sampled only while idle.
- a_bi  input  WIDTH  dividend; sampled on the accepting edge only.
- b_bi  input  WIDTH  divisor; sampled on the accepting edge only.
- busy_o  output  1  high while a division is in progress.
- y_bo  output  WIDTH  quotient.
- r_bo  output  WIDTH  remainder.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, busy_o=0, y_bo=0, r_bo=0, step counter=0, internal registers cleared.
  - Reset mid-operation aborts the division immediately. No partial result appears.
  - After rst_i rises, the first start_i is honoured on the next edge.
- States:
  - IDLE -> WORK on a rising edge with start_i=1.
  - WORK -> IDLE on the edge completing step WIDTH.
  - No other transitions.
- Accept edge (IDLE and start_i=1):
  - Latch a_bi into the dividend/quotient shift register and b_bi into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Set busy_o=1.
  - y_bo and r_bo keep their previous values.
- WORK, one step per edge:
  - Shift {rem, quo} left by 1.
  - If rem >= divisor: subtract divisor from rem and set quo LSB=1; otherwise quo LSB=0.
  - Increment the counter.
- Completion edge (step WIDTH):
  - y_bo <= quo and r_bo <= rem[WIDTH-1:0], on the same edge that busy_o <= 0.
- Latency:
  - busy_o is high for exactly WIDTH cycles. For WIDTH=8, start accepted at edge k gives busy_o=1 after edges k..k+7 and busy_o=0 after edge k+8 with results valid.
- start_i while busy_o=1 is ignored. Operand changes during WORK have no effect.
- start_i held high continuously: busy_o drops for exactly one cycle, then the next division starts with the operands present on that idle edge. This is required by controllers that release start only after seeing busy_o.
- Divide by zero (b_bi=0): y_bo = all ones, r_bo = a_bi. This falls out of the restoring algorithm and takes the normal WIDTH-cycle latency.
- Arithmetic is unsigned. The WIDTH+1-bit comparison prevents overflow. r_bo < b_bi always holds for b_bi != 0.

Optional Feature:
- Macro: DIVU_SEQ_DIVZERO_FAST_EN.
- Defined: on an accept edge with b_bi=0, the unit enters WORK for a single cycle.
  - The next edge completes with y_bo = all ones, r_bo = a_bi, busy_o=0.
  - busy_o is high for 1 cycle instead of WIDTH.
  - Nonzero divisors are unaffected.
- Undefined: divide by zero follows the normal WIDTH-cycle path with identical results.

Test Plan (WIDTH=8):
- Reset, then start with a=200, b=7 for one cycle -> busy_o high exactly 8 cycles, then y_bo=28, r_bo=4, held until the next start.
- a=5, b=9; then a=255, b=1 -> 0/5; then 255/0, each after 8 busy cycles, with outputs unchanged during busy.
- a=77, b=0 -> y_bo=255, r_bo=77; busy 8 cycles without the macro, 1 cycle with DIVU_SEQ_DIVZERO_FAST_EN.
- Start 100/3, then pulse start_i with a=9, b=2 mid-operation -> ignored; result 33/1 after 8 cycles.
- start_i held high with a=50, b=6 -> repeated 8/2 results, busy_o low exactly 1 cycle between runs.
- Drive rst_i low at busy cycle 4 of 200/7 -> busy_o, y_bo, r_bo = 0 immediately (before any clock edge). After release, 60/7 gives 8/4.

Source files
------------

// File: rtl/divu_seq.sv
// divu_seq: iterative unsigned divider, one restoring shift-subtract step per clock.
// A controller raises start_i while the unit is idle, then polls busy_o; the
// quotient (y_bo) and remainder (r_bo) update on the edge where busy_o falls
// and are held until the next accepted start.
// Optional feature macro: DIVU_SEQ_DIVZERO_FAST_EN. When defined, a zero
// divisor completes after a single WORK cycle instead of WIDTH cycles.
// Reset (rst_i) is asynchronous and active-low.

module divu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_bi,
   input  logic [WIDTH-1:0] b_bi,
   output logic             busy_o,
   output logic [WIDTH-1:0] y_bo,
   output logic [WIDTH-1:0] r_bo
);

   // The counter must be able to hold step indices 0..WIDTH-1.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      WORK = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;        // partial remainder, one bit wider than operands
   logic [WIDTH-1:0] quo;        // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] div;        // divisor captured on accept

   logic             accept;
   logic             last_step;
   logic             busy;
   logic             fast_done;

   // One restoring step, computed combinationally from the current registers.
   logic [2*WIDTH:0] pair_sh;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH:0]   rem_diff;
   logic             rem_ge;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] quo_step;

`ifdef DIVU_SEQ_DIVZERO_FAST_EN
   logic divz;                   // current division has a zero divisor

   // Remember whether the accepted divisor was zero so WORK can finish at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         divz <= 1'b0;
      end else if (accept) begin
         divz <= (b_bi == '0);
      end
   end

   assign fast_done = divz;
`else
   assign fast_done = 1'b0;
`endif

   // Shift {rem, quo} left as one register pair and try to subtract the divisor.
   always_comb begin
      pair_sh  = {rem, quo} << 1;
      rem_sh   = pair_sh[2*WIDTH:WIDTH];
      quo_sh   = pair_sh[WIDTH-1:0];
      rem_ge   = (rem_sh >= {1'b0, div});
      rem_diff = rem_sh - {1'b0, div};
      rem_step = rem_ge ? rem_diff : rem_sh;
      quo_step = quo_sh | {{(WIDTH-1){1'b0}}, rem_ge};
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state and control decode.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               accept     = 1'b1;
               state_next = WORK;
            end
         end
         WORK: begin
            busy      = 1'b1;
            last_step = (cnt == LAST_CNT) || fast_done;
            if (last_step) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy_o = busy;

   // Working registers: load on accept, step once per WORK cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
         rem <= '0;
         quo <= '0;
         div <= '0;
      end else if (accept) begin
         cnt <= '0;
         rem <= '0;
         quo <= a_bi;
         div <= b_bi;
      end else if (state == WORK) begin
         cnt <= cnt + 1'b1;
         rem <= rem_step;
         quo <= quo_step;
      end
   end

   // Result registers: written only on the completion edge, otherwise held.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         y_bo <= '0;
         r_bo <= '0;
      end else if (last_step) begin
         if (fast_done) begin
            // quo still holds the untouched dividend after the accept edge.
            y_bo <= '1;
            r_bo <= quo;
         end else begin
            y_bo <= quo_step;
            r_bo <= rem_step[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: self-checking bench for divu_seq (WIDTH=8) using directed
// cases from the test plan plus randomized operands against a plain
// arithmetic reference model.

module tb_divu_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic [W-1:0] y;
   logic [W-1:0] r;

   int n_tests = 0;
   int n_fail  = 0;

   divu_seq #(.WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .start_i(start),
      .a_bi   (a_in),
      .b_bi   (b_in),
      .busy_o (busy),
      .y_bo   (y),
      .r_bo   (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: plain unsigned division, zero divisor gives all ones / dividend.
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] rm,
                          output int lat);
      if (b == 0) begin
         q  = '1;
         rm = a;
`ifdef DIVU_SEQ_DIVZERO_FAST_EN
         lat = 1;
`else
         lat = W;
`endif
      end else begin
         q   = a / b;
         rm  = a % b;
         lat = W;
      end
   endtask

   // One division: start for one cycle, scramble operands, count busy cycles,
   // optionally poke start mid-operation, then check results and hold.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input string tag);
      logic [W-1:0] q_exp;
      logic [W-1:0] r_exp;
      logic [W-1:0] y_prev;
      logic [W-1:0] r_prev;
      int lat_exp;
      int n;
      bit held_ok;
      ref_div(a, b, q_exp, r_exp, lat_exp);
      y_prev  = y;
      r_prev  = r;
      held_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      @(negedge clk);
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      n = 0;
      while (busy && n < 50) begin
         if (y !== y_prev || r !== r_prev) held_ok = 1'b0;
         n++;
         start = (poke && n == 3);
         if (poke && n == 3) begin
            a_in = 9;
            b_in = 2;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_busy_cycles"}, n, lat_exp);
      check({tag, "_hold_during_busy"}, held_ok, 1);
      check({tag, "_y"}, y, q_exp);
      check({tag, "_r"}, r, r_exp);
      if (b != 0) check({tag, "_r_lt_b"}, (r < b), 1);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_y_held"}, y, q_exp);
      check({tag, "_r_held"}, r, r_exp);
      $display("[TB] %s: %0d / %0d -> y=%0d r=%0d busy=%0d", tag, a, b, y, r, n);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int n;
      rst   = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_y", y, 0);
      check("reset_r", r, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases.
      do_div(200, 7, 1'b0, "d200_7");
      do_div(5, 9, 1'b0, "d5_9");
      do_div(255, 1, 1'b0, "d255_1");
      do_div(255, 0, 1'b0, "d255_0");
      do_div(77, 0, 1'b0, "d77_0");
      do_div(100, 3, 1'b1, "d100_3_poke");

      // start_i held high: back-to-back runs with one idle cycle between.
      @(negedge clk);
      start = 1'b1;
      a_in  = 50;
      b_in  = 6;
      @(negedge clk);
      for (int run = 0; run < 3; run++) begin
         n = 0;
         while (busy && n < 50) begin
            n++;
            @(negedge clk);
         end
         check("held_busy_cycles", n, W);
         check("held_y", y, 8);
         check("held_r", r, 2);
         n = 0;
         while (!busy && n < 50) begin
            n++;
            @(negedge clk);
         end
         check("held_idle_cycles", n, 1);
         $display("[TB] held start run %0d: y=%0d r=%0d idle=%0d", run, y, r, n);
      end
      start = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("held_final_y", y, 8);

      // Asynchronous reset in the middle of 200/7.
      @(negedge clk);
      start = 1'b1;
      a_in  = 200;
      b_in  = 7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_y", y, 0);
      check("midreset_r", r, 0);
      $display("[TB] mid-operation reset: busy=%0d y=%0d r=%0d", busy, y, r);
      @(negedge clk);
      rst = 1'b1;
      do_div(60, 7, 1'b0, "after_reset_60_7");

      // Randomized operands, with some zero divisors mixed in.
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         do_div(ra, rb, 1'b0, $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
